// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg
//   Shared widths and the sequencer state encoding for the int2fp
//   sequencer slice. DATA_W is one beat of four complex int32 samples
//   ({i,r} per LANE_W lane). LEN_W sizes frame lengths and beat counters.
//   FIFO_W is one buffered beat plus its end-of-frame flag.
package fft_seq_pkg;

    localparam int DATA_W = 256;
    localparam int LANE_W = 64;
    localparam int LANES  = DATA_W / LANE_W;
    localparam int LEN_W  = 16;
    localparam int FIFO_W = DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fft_seq_fifo.sv
// fft_seq_fifo
//   Synchronous FIFO that buffers converted beats together with their
//   end-of-frame flag. The head entry is presented combinationally.
//   A push and a pop in the same cycle are both honoured even when the
//   FIFO is full: the popped slot is the one the new entry lands in.
// Ports
//   clk, rst        : clock, synchronous active-high reset (pointers/count)
//   push, push_data : write request and the {last, data} word
//   pop             : read request (ignored when empty)
//   head_data       : current head entry
//   empty           : no entries held
//   count           : number of entries held (0..DEPTH)
module fft_seq_fifo
    import fft_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [FIFO_W-1:0]                push_data,
    input  logic                             pop,
    output logic [FIFO_W-1:0]                head_data,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FIFO_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fft_int2fp_sequencer.sv
// fft_int2fp_sequencer
//   Feeds frames of int32 complex beats through an external fixed-latency
//   8-lane int2fp converter and re-times the FP32 results into an
//   output buffer with ready/valid handshaking. Input is only accepted when
//   the buffer is guaranteed to have room for the result, so no converter
//   output is ever dropped.
// Ports
//   s_axi_aclk, s_axi_reset : clock, synchronous active-high reset
//   start, frame_len        : frame start pulse and beats per frame
//   in_valid/in_ready/in_data        : input beat stream
//   conv_data / conv_result          : converter feed and its result
//   out_valid/out_ready/out_data/out_last : output beat stream
//   busy, done              : frame in progress, one-cycle end-of-frame
module fft_int2fp_sequencer
    import fft_seq_pkg::*;
#(
    parameter int CONV_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] conv_data,
    input  logic [DATA_W-1:0] conv_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(CONV_LATENCY + 1);
    localparam int OCC_W = CNT_W + 1;

    seq_state_t              state_q;
    seq_state_t              state_d;
    logic [LEN_W-1:0]        frame_len_q;
    logic [LEN_W-1:0]        accepted_q;
    logic [CONV_LATENCY-1:0] vld_p;
    logic [CONV_LATENCY-1:0] last_p;
    logic [INF_W-1:0]        inflight_q;

    logic                    start_ok;
    logic                    accept;
    logic                    last_beat;
    logic                    push;
    logic                    pop;
    logic [OCC_W-1:0]        occupancy;
    logic [FIFO_W-1:0]       fifo_head;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    assign conv_data = in_data;
    assign start_ok  = (state_q == ST_IDLE) && start && (frame_len != '0);
    assign accept    = in_valid && in_ready;
    assign last_beat = (accepted_q == frame_len_q - LEN_W'(1));
    assign push      = vld_p[CONV_LATENCY-1];
    assign pop       = out_valid && out_ready;

    // Credit: results still inside the converter already own a buffer slot.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q);

    always_comb begin
        in_ready = 1'b0;
        if ((state_q == ST_RUN) && (accepted_q < frame_len_q) &&
            (occupancy < OCC_W'(FIFO_DEPTH))) begin
            in_ready = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accepted_q == frame_len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            state_q     <= ST_IDLE;
            frame_len_q <= '0;
            accepted_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                frame_len_q <= frame_len;
                accepted_q  <= '0;
            end else if (accept) begin
                accepted_q <= accepted_q + LEN_W'(1);
            end
        end
    end

    // Converter tracking: stage N of vld_p/last_p follows a beat N+1 cycles
    // after it was accepted; the top stage lines up with conv_result.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            vld_p      <= '0;
            inflight_q <= '0;
        end else begin
            vld_p <= (vld_p << 1) | CONV_LATENCY'(accept);
            case ({accept, push})
                2'b10:   inflight_q <= inflight_q + INF_W'(1);
                2'b01:   inflight_q <= inflight_q - INF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        last_p <= (last_p << 1) | CONV_LATENCY'(accept && last_beat);
    end

    // Output buffer stage
    fft_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (s_axi_aclk),
        .rst       (s_axi_reset),
        .push      (push),
        .push_data ({last_p[CONV_LATENCY-1], conv_result}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DATA_W-1:0];
    assign out_last  = !fifo_empty && fifo_head[DATA_W];

endmodule

// File: tb/tb_fft_int2fp_sequencer.sv
module tb_fft_int2fp_sequencer;

    localparam int L     = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  frame_len = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic [255:0] conv_data;
    logic [255:0] conv_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    fft_int2fp_sequencer #(
        .CONV_LATENCY (L),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_reset (rst),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .conv_data   (conv_data),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // External converter model: fixed latency L, result is the bitwise
    // inverse of the feed so a pass-through of conv_data is detectable.
    logic [255:0] cpipe [L];
    always @(posedge clk) begin
        cpipe[0] <= conv_data;
        for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end
    assign conv_result = ~cpipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model state: expected {last, result} per accepted beat.
    logic [256:0] exp_q [$];
    int exp_len  = 0;
    int beat_idx = 0;
    int n_acc = 0, n_pop = 0, n_last = 0, n_done = 0;
    int first_acc_cyc = -1, first_ov_cyc = -1, last_pop_cyc = -1, done_cyc = -1;

    // Stimulus side of the scoreboard: every accepted beat predicts one output.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back({(beat_idx == exp_len - 1), ~in_data});
            beat_idx++;
            n_acc++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
    end

    // Monitor: compares every output transfer and the hold behaviour.
    logic         held_valid = 1'b0;
    logic [255:0] held_data;
    logic         held_last;
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", {255'd0, out_valid}, 256'd1);
                check("hold_data", out_data, held_data);
                check("hold_last", {255'd0, out_last}, {255'd0, held_last});
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got beat %0h expected none (cycle %0d)", out_data, cyc);
                end else begin
                    logic [256:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[255:0]);
                    check("out_last", {255'd0, out_last}, {255'd0, e[256]});
                end
                n_pop++;
                if (out_last) n_last++;
                last_pop_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_acc = 0; n_pop = 0; n_last = 0; n_done = 0;
        first_acc_cyc = -1; first_ov_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    endtask

    task automatic run_frame(input int len, input int vpct, input int rpct,
                             input int hold, input bit mid_start, input int budget);
        int cnt;
        clear_stats();
        exp_len   = len;
        beat_idx  = 0;
        frame_len = 16'(len);
        start     = 1'b1;
        in_valid  = 1'b0;
        tick();
        start = 1'b0;
        check("busy_run", {255'd0, busy}, 256'd1);
        cnt = 0;
        while (n_done == 0 && cnt < budget) begin
            if (hold > 0 && cnt == hold) begin
                check_int("credit_accepts", n_acc, DEPTH);
                check("credit_in_ready", {255'd0, in_ready}, 256'd0);
            end
            in_valid  = ($urandom_range(99) < vpct);
            in_data   = rand256();
            out_ready = (cnt < hold) ? 1'b0 : ($urandom_range(99) < rpct);
            start     = mid_start && (cnt == 3);
            frame_len = (mid_start && cnt == 3) ? 16'd3 : 16'(len);
            tick();
            cnt++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (n_done == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no done after %0d cycles, frame_len %0d", budget, len);
        end
        tick();
        tick();
        check_int("frame_accepts", n_acc, len);
        check_int("frame_pops", n_pop, len);
        check_int("frame_lasts", n_last, 1);
        check_int("frame_dones", n_done, 1);
        check_int("frame_sb_empty", exp_q.size(), 0);
        check("idle_after", {255'd0, busy}, 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst_out_last", {255'd0, out_last}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        rst = 1'b0;
        tick();

        // Short frame, full throughput: latency, back-to-back output, done timing.
        run_frame(4, 100, 100, 0, 1'b0, 100);
        check_int("latency", first_ov_cyc, first_acc_cyc + 1 + L);
        check_int("burst_len", last_pop_cyc, first_ov_cyc + 3);
        check_int("done_timing", done_cyc, last_pop_cyc + 2);

        // Output stalled: credit stops input at DEPTH, then everything drains in order.
        run_frame(20, 100, 100, 12, 1'b0, 400);

        // Zero-length start is ignored.
        clear_stats();
        frame_len = 16'd0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("len0_busy", {255'd0, busy}, 256'd0);
        check_int("len0_done", n_done, 0);

        // Start during RUN is ignored (frame still delivers its own 10 beats).
        run_frame(10, 100, 100, 0, 1'b1, 200);

        // Random handshakes on a long frame.
        run_frame(100, 50, 50, 0, 1'b0, 3000);

        // Reset with three beats inside the converter.
        clear_stats();
        exp_len   = 20;
        beat_idx  = 0;
        frame_len = 16'd20;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            in_data = rand256();
            tick();
        end
        check_int("pre_rst_accepts", n_acc, 3);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        check("midrst_busy", {255'd0, busy}, 256'd0);
        check("midrst_in_ready", {255'd0, in_ready}, 256'd0);
        check("midrst_done", {255'd0, done}, 256'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (8) tick();
        check("no_stale_valid", {255'd0, out_valid}, 256'd0);
        run_frame(5, 100, 100, 0, 1'b0, 100);

        // A few random-length frames.
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(40, 1)), 70, 60, 0, 1'b0, 2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
